// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit scheduler: register map, status bits
// and the Wishbone master state encoding.
package uart_pkg;

  localparam logic [4:0] DATA     = 5'h0;
  localparam logic [4:0] STATUS   = 5'h2;
  localparam int         TX_EMPTY = 5;
  localparam int         CTS      = 0;

  typedef enum logic [2:0] {
    IDLE,
    POLL_REQ,
    POLL_ACK,
    WR_REQ,
    WR_ACK
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first asserted request at or after ptr (wrapping)
// wins, reported both one-hot and as an index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [GW-1:0]      gnt_idx,
  output logic               gnt_any
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_any && req[idx]) begin
        gnt_any      = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates byte streams from several requesters onto a Wishbone UART:
// polls STATUS until the transmitter is free, then writes the byte to DATA.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 15,
  parameter int CTS_FLOW    = 0
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_reset_n_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*8-1:0]       req_data_i,
  input  logic [NUM_REQ-1:0]         req_last_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       wb_cyc_o,
  output logic                       wb_strobe_o,
  output logic                       wb_write_o,
  output logic [4:0]                 wb_addr_o,
  output logic [7:0]                 wb_data_o,
  input  logic [7:0]                 wb_data_i,
  input  logic                       wb_ack_i,
  input  logic                       wb_stall_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_o,
  output logic                       busy_o,
  output logic                       timeout_o
);

  localparam int             GW   = $clog2(NUM_REQ);
  localparam int             TW   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0]  TMAX = TW'(ACK_TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [GW-1:0]        grant_q, rr_ptr_q, arb_idx;
  logic                 lock_q, take, arb_any, sel_last, tx_ok;
  logic [TW-1:0]        timer_q;
  logic [7:0]           byte_q, sel_byte;
  logic [NUM_REQ-1:0]   lock_mask, arb_req, arb_gnt;

  // While a packet is in flight only its owner may be granted again.
  assign lock_mask = lock_q ? (NUM_REQ'(1) << grant_q) : '1;
  assign arb_req   = req_valid_i & lock_mask;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .GW(GW)) u_arb (
    .req     (arb_req),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  always_comb begin
    sel_byte = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_byte = req_data_i[8*i +: 8];
        sel_last = req_last_i[i];
      end
    end
  end

  assign tx_ok = wb_data_i[TX_EMPTY] && ((CTS_FLOW == 0) || !wb_data_i[CTS]);

  always_comb begin
    state_d     = state_q;
    take        = 1'b0;
    wb_cyc_o    = 1'b0;
    wb_strobe_o = 1'b0;
    wb_write_o  = 1'b0;
    wb_addr_o   = DATA;
    wb_data_o   = '0;
    timeout_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          take    = 1'b1;
          state_d = POLL_REQ;
        end
      end
      POLL_REQ: begin
        wb_cyc_o    = 1'b1;
        wb_strobe_o = 1'b1;
        wb_addr_o   = STATUS;
        if (!wb_stall_i) state_d = POLL_ACK;
      end
      POLL_ACK: begin
        wb_cyc_o  = 1'b1;
        wb_addr_o = STATUS;
        if (wb_ack_i) begin
          state_d = tx_ok ? WR_REQ : POLL_REQ;
        end else if (timer_q == TMAX) begin
          timeout_o = 1'b1;
          state_d   = IDLE;
        end
      end
      WR_REQ: begin
        wb_cyc_o    = 1'b1;
        wb_strobe_o = 1'b1;
        wb_write_o  = 1'b1;
        wb_data_o   = byte_q;
        if (!wb_stall_i) state_d = WR_ACK;
      end
      WR_ACK: begin
        wb_cyc_o   = 1'b1;
        wb_write_o = 1'b1;
        if (wb_ack_i) begin
          state_d = IDLE;
        end else if (timer_q == TMAX) begin
          timeout_o = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gated by reset so an asserted reset never reports a byte as taken.
  assign req_ready_o = (take && wb_reset_n_i) ? arb_gnt : '0;
  assign busy_o      = (state_q != IDLE);
  assign grant_o     = grant_q;

  always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      lock_q   <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        grant_q  <= arb_idx;
        rr_ptr_q <= (arb_idx == GW'(NUM_REQ - 1)) ? '0 : arb_idx + GW'(1);
        lock_q   <= !sel_last;
      end else if (timeout_o) begin
        lock_q <= 1'b0;
      end
      if ((state_q == POLL_ACK || state_q == WR_ACK) && state_d == state_q)
        timer_q <= timer_q + TW'(1);
      else
        timer_q <= '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (take) byte_q <= sel_byte;
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a small Wishbone UART slave model.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid_i, req_last_i, req_ready_o;
  logic [31:0] req_data_i;
  logic        wb_cyc_o, wb_strobe_o, wb_write_o, wb_ack_i, wb_stall_i;
  logic [4:0]  wb_addr_o;
  logic [7:0]  wb_data_o, wb_data_i;
  logic [1:0]  grant_o;
  logic        busy_o, timeout_o;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.NUM_REQ(4), .ACK_TIMEOUT(15), .CTS_FLOW(1)) dut (
    .wb_clk_i(clk), .wb_reset_n_i(rst_n),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o),
    .wb_cyc_o(wb_cyc_o), .wb_strobe_o(wb_strobe_o), .wb_write_o(wb_write_o),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i),
    .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  // Slave model controls (written by the stimulus only)
  int        poll_base = 0, busy_reads = 0, wr_delay = 0;
  logic [7:0] busy_val = 8'h00;
  bit        no_ack_write = 1'b0;

  // Slave model state (written by the slave only)
  int        poll_total = 0, wr_total = 0, to_cnt = 0, pend_cnt = 0;
  bit        pend = 1'b0;
  logic [7:0] pend_data = 8'h00;
  logic [4:0] pend_addr = 5'h00;
  logic [7:0] wr_log [0:63];
  logic [4:0] wr_addr_log [0:63];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack_i  <= 1'b0;
      wb_data_i <= 8'h00;
      pend      <= 1'b0;
    end else begin
      wb_ack_i <= 1'b0;
      if (timeout_o) to_cnt <= to_cnt + 1;
      if (wb_cyc_o && wb_strobe_o && !wb_stall_i) begin
        if (!wb_write_o) begin
          wb_ack_i   <= 1'b1;
          wb_data_i  <= (poll_total - poll_base < busy_reads) ? busy_val : 8'h20;
          poll_total <= poll_total + 1;
        end else if (!no_ack_write) begin
          if (wr_delay == 0) begin
            wb_ack_i              <= 1'b1;
            wr_log[wr_total]      <= wb_data_o;
            wr_addr_log[wr_total] <= wb_addr_o;
            wr_total              <= wr_total + 1;
          end else begin
            pend      <= 1'b1;
            pend_cnt  <= wr_delay - 1;
            pend_data <= wb_data_o;
            pend_addr <= wb_addr_o;
          end
        end
      end
      if (pend) begin
        if (pend_cnt == 0) begin
          wb_ack_i              <= 1'b1;
          wr_log[wr_total]      <= pend_data;
          wr_addr_log[wr_total] <= pend_addr;
          wr_total              <= wr_total + 1;
          pend                  <= 1'b0;
        end else begin
          pend_cnt <= pend_cnt - 1;
        end
      end
    end
  end

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    int          n_busy;
    logic [7:0]  bval;
    int          exp_grant;
    logic [7:0]  exp_byte;
    int          exp_polls;
  } row_t;

  row_t rows [10];
  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name, output logic [3:0] v);
    int n = 0;
    v = '0;
    while (n < 60) begin
      if (req_ready_o != 4'b0) begin
        v = req_ready_o;
        break;
      end
      @(negedge clk);
      n++;
    end
    if (v == 4'b0) begin
      total++; bad++;
      $display("FAIL %s: no ready pulse within %0d cycles", name, n);
    end
  endtask

  task automatic wait_idle(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_o && n < 100);
    if (busy_o) begin
      total++; bad++;
      $display("FAIL %s: still busy after %0d cycles", name, n);
    end
  endtask

  task automatic wait_wr_accept(input string name);
    int n = 0;
    while (!(wb_cyc_o && wb_strobe_o && wb_write_o && !wb_stall_i) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      total++; bad++;
      $display("FAIL %s: write strobe never offered", name);
    end
  endtask

  task automatic run_row(input row_t r, input string name);
    logic [3:0] v;
    int wbase, n;
    wbase      = wr_total;
    poll_base  = poll_total;
    busy_reads = r.n_busy;
    busy_val   = r.bval;
    req_valid_i = r.valid;
    req_data_i  = r.data;
    req_last_i  = r.last;
    #1;
    wait_ready({name, "_ready"}, v);
    chk({name, "_ready"}, 32'(v), 32'(4'b1 << r.exp_grant));
    @(posedge clk); #1;
    req_valid_i = '0;
    chk({name, "_grant"}, 32'(grant_o), 32'(r.exp_grant));
    chk({name, "_busy"}, 32'(busy_o), 32'd1);
    wait_idle({name, "_idle"}, n);
    chk({name, "_cycles"}, 32'(n), 32'(3 + 2 * r.exp_polls));
    chk({name, "_nwr"}, 32'(wr_total), 32'(wbase + 1));
    chk({name, "_byte"}, 32'(wr_log[wbase]), 32'(r.exp_byte));
    chk({name, "_addr"}, 32'(wr_addr_log[wbase]), 32'h0);
    chk({name, "_polls"}, 32'(poll_total - poll_base), 32'(r.exp_polls));
  endtask

  initial begin
    logic [3:0] v;
    int n, wbase, tc;
    row_t r;

    rows[0] = '{4'hF, 32'h13121110, 4'hF, 0, 8'h00, 0, 8'h10, 1};
    rows[1] = '{4'hE, 32'h13121110, 4'hF, 0, 8'h00, 1, 8'h11, 1};
    rows[2] = '{4'hC, 32'h13121110, 4'hF, 0, 8'h00, 2, 8'h12, 1};
    rows[3] = '{4'h8, 32'h13121110, 4'hF, 0, 8'h00, 3, 8'h13, 1};
    rows[4] = '{4'hF, 32'h23222120, 4'hF, 2, 8'h00, 0, 8'h20, 3};
    rows[5] = '{4'h3, 32'h00003130, 4'hF, 1, 8'h21, 1, 8'h31, 2};
    rows[6] = '{4'h3, 32'h00003130, 4'hF, 0, 8'h00, 0, 8'h30, 1};
    rows[7] = '{4'h9, 32'h43000040, 4'hF, 0, 8'h00, 3, 8'h43, 1};
    rows[8] = '{4'h4, 32'h00410000, 4'h4, 0, 8'h00, 2, 8'h41, 1};
    rows[9] = '{4'h1, 32'h00000055, 4'h1, 1, 8'h01, 0, 8'h55, 2};

    req_valid_i = '0; req_data_i = '0; req_last_i = '0; wb_stall_i = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wb", 32'({wb_cyc_o, wb_strobe_o, wb_write_o, wb_addr_o, wb_data_o}), 32'h0);
    chk("rst_ctl", 32'({req_ready_o, grant_o, busy_o, timeout_o}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_wb", 32'({wb_cyc_o, wb_strobe_o, req_ready_o, busy_o}), 32'h0);

    for (int i = 0; i < 10; i++) run_row(rows[i], $sformatf("row%0d", i));
    chk("rows_no_timeout", 32'(to_cnt), 32'd0);

    // Packet lock: requester 1 sends three bytes while requester 0 waits.
    wbase = wr_total; busy_reads = 0;
    req_valid_i = 4'b0011; req_data_i = 32'h0000B1A0; req_last_i = 4'b0001;
    #1;
    wait_ready("lock_b1", v); chk("lock_b1", 32'(v), 32'h2);
    @(posedge clk); #1;
    chk("ready_one_cycle", 32'(req_ready_o), 32'h0);
    req_data_i = 32'h0000B2A0;
    wait_ready("lock_b2", v); chk("lock_b2", 32'(v), 32'h2);
    @(posedge clk); #1;
    req_data_i = 32'h0000B3A0; req_last_i = 4'b0011;
    wait_ready("lock_b3", v); chk("lock_b3", 32'(v), 32'h2);
    @(posedge clk); #1;
    wait_ready("lock_a0", v); chk("lock_a0", 32'(v), 32'h1);
    @(posedge clk); #1;
    req_valid_i = '0;
    wait_idle("lock_idle", n);
    chk("lock_wr0", 32'(wr_log[wbase]), 32'hB1);
    chk("lock_wr1", 32'(wr_log[wbase + 1]), 32'hB2);
    chk("lock_wr2", 32'(wr_log[wbase + 2]), 32'hB3);
    chk("lock_wr3", 32'(wr_log[wbase + 3]), 32'hA0);

    // Stalled status strobe must be held unchanged.
    wbase = wr_total;
    wb_stall_i = 1'b1;
    req_valid_i = 4'b0010; req_data_i = 32'h00006600; req_last_i = 4'b0010;
    #1;
    wait_ready("stall_ready", v); chk("stall_ready", 32'(v), 32'h2);
    @(posedge clk); #1;
    req_valid_i = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_hold", 32'({wb_cyc_o, wb_strobe_o, wb_write_o, wb_addr_o}), 32'({3'b110, 5'h2}));
    end
    wb_stall_i = 1'b0;
    wait_idle("stall_idle", n);
    chk("stall_byte", 32'(wr_log[wbase]), 32'h66);

    // Write never acknowledged: timeout, lock cleared, next requester served.
    wbase = wr_total; tc = to_cnt; no_ack_write = 1'b1;
    req_valid_i = 4'b0100; req_data_i = 32'h00550000; req_last_i = 4'b0000;
    #1;
    wait_ready("to_ready", v); chk("to_ready", 32'(v), 32'h4);
    @(posedge clk); #1;
    req_valid_i = '0;
    wait_wr_accept("to_accept");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!timeout_o && n < 40);
    chk("to_latency", 32'(n), 32'd15);
    @(negedge clk);
    chk("to_after", 32'({wb_cyc_o, busy_o, timeout_o}), 32'h0);
    chk("to_pulses", 32'(to_cnt - tc), 32'd1);
    no_ack_write = 1'b0;
    r = '{4'h2, 32'h00006700, 4'h2, 0, 8'h00, 1, 8'h67, 1};
    run_row(r, "after_to");

    // Ack arriving in the very cycle the timer expires is a normal ack.
    wbase = wr_total; tc = to_cnt; wr_delay = 14;
    req_valid_i = 4'b0001; req_data_i = 32'h00000078; req_last_i = 4'b0001;
    #1;
    wait_ready("late_ready", v); chk("late_ready", 32'(v), 32'h1);
    @(posedge clk); #1;
    req_valid_i = '0;
    wait_idle("late_idle", n);
    chk("late_cycles", 32'(n), 32'd19);
    chk("late_no_to", 32'(to_cnt - tc), 32'd0);
    chk("late_byte", 32'(wr_log[wbase]), 32'h78);
    wr_delay = 0;

    // Reset in WR_ACK: everything drops at once, no ready while held.
    no_ack_write = 1'b1;
    req_valid_i = 4'b1000; req_data_i = 32'h99000000; req_last_i = 4'b1000;
    #1;
    wait_ready("rst_ready", v); chk("rst_ready", 32'(v), 32'h8);
    wait_wr_accept("rst_accept");
    @(negedge clk);
    chk("in_wr_ack", 32'({wb_cyc_o, wb_write_o, busy_o}), 32'h7);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wb", 32'({wb_cyc_o, wb_strobe_o, wb_write_o, wb_addr_o, wb_data_o}), 32'h0);
    chk("mid_rst_ctl", 32'({req_ready_o, grant_o, busy_o, timeout_o}), 32'h0);
    @(negedge clk);
    chk("mid_rst_hold", 32'({req_ready_o, busy_o, wb_cyc_o}), 32'h0);
    req_valid_i = '0; no_ack_write = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    r = '{4'h9, 32'h880000AA, 4'h9, 0, 8'h00, 0, 8'hAA, 1};
    run_row(r, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
